// File: rtl/axi4_ram_responder_if.sv
// AXI4 bus bundle between a master and the axi4_ram_responder RAM endpoint.
// The slave modport is the responder's view; the master modport drives requests.
interface axi4_ram_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Write address channel
  logic                  awvalids;
  logic                  awreadys;
  logic [ID_WIDTH-1:0]   awids;
  logic [ADDR_WIDTH-1:0] awaddrs;
  logic [7:0]            awlens;

  // Write data channel
  logic                  wvalids;
  logic                  wreadys;
  logic [DATA_WIDTH-1:0] wdatas;
  logic [STRB_WIDTH-1:0] wstrbs;
  logic                  wlasts;

  // Write response channel
  logic                  bvalids;
  logic                  breadys;
  logic [ID_WIDTH-1:0]   bids;
  logic [1:0]            bresps;

  // Read address channel
  logic                  arvalids;
  logic                  arreadys;
  logic [ID_WIDTH-1:0]   arids;
  logic [ADDR_WIDTH-1:0] araddrs;
  logic [7:0]            arlens;

  // Read data channel
  logic                  rvalids;
  logic                  rreadys;
  logic [ID_WIDTH-1:0]   rids;
  logic [DATA_WIDTH-1:0] rdatas;
  logic [1:0]            rresps;
  logic                  rlasts;

  modport slave (
    input  awvalids, awids, awaddrs, awlens,
    input  wvalids, wdatas, wstrbs, wlasts,
    input  breadys,
    input  arvalids, arids, araddrs, arlens,
    input  rreadys,
    output awreadys, wreadys, bvalids, bids, bresps,
    output arreadys, rvalids, rids, rdatas, rresps, rlasts
  );

  modport master (
    output awvalids, awids, awaddrs, awlens,
    output wvalids, wdatas, wstrbs, wlasts,
    output breadys,
    output arvalids, arids, araddrs, arlens,
    output rreadys,
    input  awreadys, wreadys, bvalids, bids, bresps,
    input  arreadys, rvalids, rids, rdatas, rresps, rlasts
  );
endinterface

// File: rtl/axi4_ram_responder.sv
// AXI4 slave terminating INCR bursts into a word-addressed register-array RAM.
// Define AXI_RAM_DECERR_EN to answer addresses beyond the array with DECERR.
module axi4_ram_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 256
) (
  input logic                 aclk,
  input logic                 aresetn,
  axi4_ram_responder_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFFS       = $clog2(STRB_WIDTH);
  localparam int IDXW       = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [IDXW-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Word indices of the incoming start addresses; byte-offset bits are dropped.
  idx_t aw_idx, ar_idx;
  assign aw_idx = bus.awaddrs[OFFS +: IDXW];
  assign ar_idx = bus.araddrs[OFFS +: IDXW];

  logic aw_oor, ar_oor;
`ifdef AXI_RAM_DECERR_EN
  assign aw_oor = (bus.awaddrs >> (OFFS + IDXW)) != '0;
  assign ar_oor = (bus.araddrs >> (OFFS + IDXW)) != '0;
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  // Offset and (by default) high address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.awaddrs, bus.araddrs};

  // ---------------------------------------------------------------- write path
  wstate_e             w_state;
  logic [ID_WIDTH-1:0] w_id;
  idx_t                w_idx;
  logic [7:0]          w_len, w_cnt;
  logic                w_err, w_oor;
  logic                awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0] bid_q;
  logic [1:0]          bresp_q;

  logic w_fire, w_last_beat, w_beat_err;
  assign w_fire      = bus.wvalids & wready_q;
  assign w_last_beat = (w_cnt == w_len);
  assign w_beat_err  = bus.wlasts != w_last_beat;

  // NOTE: state registers use non-blocking assignments so every register in
  // the block samples the pre-edge values, independent of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state   <= W_IDLE;
      w_id      <= '0;
      w_idx     <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_err     <= 1'b0;
      w_oor     <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (bus.awvalids && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_id      <= bus.awids;
            w_idx     <= aw_idx;
            w_len     <= bus.awlens;
            w_cnt     <= '0;
            w_err     <= 1'b0;
            w_oor     <= aw_oor;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_idx <= w_idx + idx_t'(1);
            w_cnt <= w_cnt + 8'd1;
            w_err <= w_err | w_beat_err;
            if (w_last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= w_id;
              // Address decode failure outranks a wlast framing error.
              if (w_oor)                    bresp_q <= RESP_DECERR;
              else if (w_err || w_beat_err) bresp_q <= RESP_SLVERR;
              else                          bresp_q <= RESP_OKAY;
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bus.breadys) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left without a reset so it maps
  // onto plain registers/RAM; contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (w_fire && !w_oor) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (bus.wstrbs[b]) mem[w_idx][8*b +: 8] <= bus.wdatas[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read path
  rstate_e               r_state;
  idx_t                  r_idx;
  logic [7:0]            r_len, r_cnt;
  logic                  r_oor;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  // r_idx always points at the word for the beat after the one on the bus,
  // so an accepted beat reloads rdata in the same edge (full-rate bursts).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= R_IDLE;
      r_idx     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_oor     <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (bus.arvalids && arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= bus.arids;
            r_len     <= bus.arlens;
            r_cnt     <= '0;
            r_oor     <= ar_oor;
            rlast_q   <= (bus.arlens == 8'd0);
            rdata_q   <= ar_oor ? '0 : mem[ar_idx];
            rresp_q   <= ar_oor ? RESP_DECERR : RESP_OKAY;
            r_idx     <= ar_idx + idx_t'(1);
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (bus.rreadys) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              rlast_q <= ((r_cnt + 8'd1) == r_len);
              rdata_q <= r_oor ? '0 : mem[r_idx];
              r_idx   <= r_idx + idx_t'(1);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign bus.awreadys = awready_q;
  assign bus.wreadys  = wready_q;
  assign bus.bvalids  = bvalid_q;
  assign bus.bids     = bid_q;
  assign bus.bresps   = bresp_q;
  assign bus.arreadys = arready_q;
  assign bus.rvalids  = rvalid_q;
  assign bus.rids     = rid_q;
  assign bus.rdatas   = rdata_q;
  assign bus.rresps   = rresp_q;
  assign bus.rlasts   = rlast_q;
endmodule

// File: tb/tb_axi4_ram_responder.sv
// Self-checking bench for axi4_ram_responder: directed bursts plus randomized
// traffic compared against an array model of the word memory.
module tb_axi4_ram_responder;
  localparam int DEPTH = 256;
  localparam int LIMIT = 200;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi4_ram_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

  axi4_ram_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .DEPTH(DEPTH)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory: one entry per word, byte lanes merged by strobe.
  logic [31:0] model [DEPTH];
  logic [31:0] wdat  [256];
  logic [3:0]  wstb  [256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr, input int beat);
    return (int'((addr >> 2) % 32'(DEPTH)) + beat) % DEPTH;
  endfunction

  function automatic bit oor(input logic [31:0] addr);
`ifdef AXI_RAM_DECERR_EN
    return addr >= 32'(DEPTH * 4);
`else
    return (addr != addr);
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic axi_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                           input logic [3:0] id, input int last_at, input bit rand_bp);
    int t;
    bit timed_out;
    bit err;
    logic [1:0] exp_resp, hold_resp;
    logic [3:0] hold_id;
    timed_out = 0;
    err = 0;
    @(negedge aclk);
    bus.awvalids = 1'b1; bus.awids = id; bus.awaddrs = addr; bus.awlens = len;
    t = 0;
    while (!bus.awreadys && t < LIMIT) begin @(negedge aclk); t++; end
    check({tag, "_aw_wait"}, 64'(t < LIMIT), 64'd1);
    @(negedge aclk);
    bus.awvalids = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (rand_bp) repeat ($urandom_range(0, 2)) @(negedge aclk);
      bus.wvalids = 1'b1; bus.wdatas = wdat[b]; bus.wstrbs = wstb[b];
      bus.wlasts = (b == last_at);
      t = 0;
      while (!bus.wreadys && t < LIMIT) begin @(negedge aclk); t++; end
      if (t >= LIMIT) timed_out = 1;
      @(negedge aclk);
      bus.wvalids = 1'b0; bus.wlasts = 1'b0;
      if (!oor(addr)) model[word_of(addr, b)] = merge(model[word_of(addr, b)], wdat[b], wstb[b]);
      if ((b == last_at) != (b == int'(len))) err = 1;
    end
    check({tag, "_w_beats_taken"}, 64'(timed_out), 64'd0);
    exp_resp = oor(addr) ? 2'b11 : (err ? 2'b10 : 2'b00);
    t = 0;
    while (!bus.bvalids && t < LIMIT) begin @(negedge aclk); t++; end
    check({tag, "_b_wait"}, 64'(t < LIMIT), 64'd1);
    check({tag, "_bresp"}, 64'(bus.bresps), 64'(exp_resp));
    check({tag, "_bid"}, 64'(bus.bids), 64'(id));
    hold_resp = bus.bresps;
    hold_id   = bus.bids;
    if (rand_bp) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge aclk);
        check({tag, "_b_stable"}, 64'({bus.bvalids, bus.bids, bus.bresps}),
              64'({1'b1, hold_id, hold_resp}));
      end
    end
    bus.breadys = 1'b1;
    @(negedge aclk);
    bus.breadys = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id, input bit rand_bp);
    int t;
    logic [31:0] exp;
    logic [38:0] hold;
    @(negedge aclk);
    bus.arvalids = 1'b1; bus.arids = id; bus.araddrs = addr; bus.arlens = len;
    t = 0;
    while (!bus.arreadys && t < LIMIT) begin @(negedge aclk); t++; end
    check({tag, "_ar_wait"}, 64'(t < LIMIT), 64'd1);
    @(negedge aclk);
    bus.arvalids = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      t = 0;
      while (!bus.rvalids && t < LIMIT) begin @(negedge aclk); t++; end
      check({tag, "_r_wait"}, 64'(t < LIMIT), 64'd1);
      exp = oor(addr) ? 32'h0 : model[word_of(addr, b)];
      check({tag, "_rdata"}, 64'(bus.rdatas), 64'(exp));
      check({tag, "_rlast"}, 64'(bus.rlasts), 64'(b == int'(len)));
      check({tag, "_rid_rresp"}, 64'({bus.rids, bus.rresps}),
            64'({id, oor(addr) ? 2'b11 : 2'b00}));
      hold = {bus.rdatas, bus.rlasts, bus.rids, bus.rresps};
      if (rand_bp) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge aclk);
          check({tag, "_r_stable"}, 64'({bus.rvalids, bus.rdatas, bus.rlasts, bus.rids, bus.rresps}),
                64'({1'b1, hold}));
        end
      end
      bus.rreadys = 1'b1;
      @(negedge aclk);
      bus.rreadys = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    int          la;

    bus.awvalids = 0; bus.awids = 0; bus.awaddrs = 0; bus.awlens = 0;
    bus.wvalids = 0; bus.wdatas = 0; bus.wstrbs = 0; bus.wlasts = 0; bus.breadys = 0;
    bus.arvalids = 0; bus.arids = 0; bus.araddrs = 0; bus.arlens = 0; bus.rreadys = 0;

    // Reset state: every output low.
    #12;
    check("reset_ready", 64'({bus.awreadys, bus.wreadys, bus.arreadys}), 64'd0);
    check("reset_valid", 64'({bus.bvalids, bus.rvalids, bus.rlasts}), 64'd0);
    check("reset_payload", 64'({bus.bids, bus.bresps, bus.rids, bus.rresps, bus.rdatas}), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("post_reset_awready", 64'(bus.awreadys), 64'd1);
    check("post_reset_arready", 64'(bus.arreadys), 64'd1);

    // W beat ahead of AW must stall.
    bus.wvalids = 1'b1; bus.wdatas = 32'hDEAD_BEEF; bus.wstrbs = 4'hF;
    repeat (2) begin
      @(negedge aclk);
      check("w_before_aw_stalled", 64'(bus.wreadys), 64'd0);
    end
    bus.wvalids = 1'b0;

    // Basic 4-beat burst at 0x10.
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + 32'(i); wstb[i] = 4'hF; end
    axi_write("burst4", 32'h10, 8'd3, 4'h5, 3, 0);
    axi_read("burst4_rd", 32'h10, 8'd3, 4'h6, 0);

    // Byte strobes merge into an existing word.
    wdat[0] = 32'hAABB_CCDD; wstb[0] = 4'hF;
    axi_write("strb_init", 32'h40, 8'd0, 4'h1, 0, 0);
    wdat[0] = 32'h1122_3344; wstb[0] = 4'b0101;
    axi_write("strb_part", 32'h40, 8'd0, 4'h1, 0, 0);
    axi_read("strb_rd", 32'h40, 8'd0, 4'h2, 0);

    // Index wrap 254,255,0,1.
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hB0 + 32'(i); wstb[i] = 4'hF; end
    axi_write("wrap", 32'h3F8, 8'd3, 4'h3, 3, 0);
    axi_read("wrap_rd", 32'h3F8, 8'd3, 4'h3, 0);
    axi_read("wrap_rd0", 32'h0, 8'd1, 4'h4, 0);

    // Early wlast: all beats still consumed, SLVERR.
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hC0 + 32'(i); wstb[i] = 4'hF; end
    axi_write("early_wlast", 32'h80, 8'd3, 4'hC, 1, 0);
    axi_read("early_wlast_rd", 32'h80, 8'd3, 4'hC, 1);

    // Concurrent write and read on disjoint words with backpressure.
    for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    fork
      axi_write("conc_w", 32'h190, 8'd3, 4'h2, 3, 1);
      axi_read("conc_r", 32'h10, 8'd3, 4'h7, 1);
    join

    // Same-cycle write and read of word 16: the read returns the old word.
    @(negedge aclk);
    bus.awvalids = 1'b1; bus.awaddrs = 32'h40; bus.awlens = 8'd0; bus.awids = 4'h3;
    check("col_awready", 64'(bus.awreadys), 64'd1);
    @(negedge aclk);
    bus.awvalids = 1'b0;
    bus.wvalids = 1'b1; bus.wdatas = 32'h5A5A_0001; bus.wstrbs = 4'hF; bus.wlasts = 1'b1;
    bus.arvalids = 1'b1; bus.araddrs = 32'h40; bus.arlens = 8'd0; bus.arids = 4'h9;
    check("col_ready", 64'({bus.wreadys, bus.arreadys}), 64'b11);
    @(negedge aclk);
    bus.wvalids = 1'b0; bus.wlasts = 1'b0; bus.arvalids = 1'b0;
    check("col_rvalid_bvalid", 64'({bus.rvalids, bus.bvalids, bus.bresps}), 64'b1100);
    check("col_old_data", 64'(bus.rdatas), 64'(model[16]));
    model[16] = 32'h5A5A_0001;
    bus.rreadys = 1'b1; bus.breadys = 1'b1;
    @(negedge aclk);
    bus.rreadys = 1'b0; bus.breadys = 1'b0;
    axi_read("col_new_data", 32'h40, 8'd0, 4'h9, 0);

    // Randomized bursts: full write, random-strobe overwrite, readback.
    for (int it = 0; it < 12; it++) begin
      a = $urandom;
      l = 8'($urandom_range(0, 7));
      for (int i = 0; i <= int'(l); i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
      axi_write("rnd_full", a, l, 4'($urandom), int'(l), 1);
      for (int i = 0; i <= int'(l); i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
      la = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(l) + 1)) : int'(l);
      axi_write("rnd_strb", a, l, 4'($urandom), la, 1);
      axi_read("rnd_rd", a, l, 4'($urandom), 1);
    end

    // Reset pulsed in the middle of a stalled read burst.
    @(negedge aclk);
    bus.arvalids = 1'b1; bus.araddrs = 32'h10; bus.arlens = 8'd3; bus.arids = 4'h1;
    @(negedge aclk);
    bus.arvalids = 1'b0;
    check("midrst_rvalid_before", 64'(bus.rvalids), 64'd1);
    #2 aresetn = 1'b0;
    #1;
    check("midrst_rvalid_async", 64'({bus.rvalids, bus.rlasts, bus.arreadys, bus.awreadys}), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("midrst_arready_after", 64'({bus.arreadys, bus.rvalids}), 64'b10);
    axi_read("midrst_mem_kept", 32'h10, 8'd3, 4'h1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4_ram_responder.md
Name: axi4_ram_responder

Overview:
- AXI4 slave endpoint (responder) that terminates write and read transactions into an internal word-addressed register-array memory.
- Sits at the far (slave) end of AXI register-slice chains; used as a bring-up target, scratch RAM and bench memory model.
- Write path (AW/W/B) and read path (AR/R) are independent state machines sharing one array.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; power of two, at least 8.
- ID_WIDTH, 4, transaction ID width.
- DEPTH, 256, memory words; power of two, at least 2.
- STRB_WIDTH, DATA_WIDTH/8, derived.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- awvalids  in  1  write address valid
- awreadys  out  1  write address ready
- awids  in  ID_WIDTH  write ID
- awaddrs  in  ADDR_WIDTH  write start byte address
- awlens  in  8  write beats minus 1
- wvalids  in  1  write data valid
- wreadys  out  1  write data ready
- wdatas  in  DATA_WIDTH  write data
- wstrbs  in  STRB_WIDTH  byte enables
- wlasts  in  1  last write beat
- bvalids  out  1  write response valid
- breadys  in  1  write response ready
- bids  out  ID_WIDTH  response ID
- bresps  out  2  write response
- arvalids  in  1  read address valid
- arreadys  out  1  read address ready
- arids  in  ID_WIDTH  read ID
- araddrs  in  ADDR_WIDTH  read start byte address
- arlens  in  8  read beats minus 1
- rvalids  out  1  read data valid
- rreadys  in  1  read data ready
- rids  out  ID_WIDTH  read ID
- rdatas  out  DATA_WIDTH  read data
- rresps  out  2  read response
- rlasts  out  1  last read beat

Behaviour:
- Clock and reset: one clock aclk; reset aresetn is asynchronous, active-low.
- Reset values: all outputs 0, including awreadys and arreadys. Memory contents are not reset. Asserting aresetn mid-burst aborts both FSMs immediately to IDLE; completed beats remain in memory.
- Addressing:
  - Word index = byte address >> log2(STRB_WIDTH), taken modulo DEPTH.
  - Low byte-offset bits are ignored; beats are always full width.
  - Bursts are INCR only: index increments by 1 per beat and wraps DEPTH-1 -> 0.
  - Beat counter is 8 bits, compared against the captured len.
- Write FSM, states W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awreadys=1. On awvalids&awreadys, capture id, index and len; clear error flag; go to W_DATA.
  - W_DATA: wreadys=1. Each handshake writes the bytes whose wstrbs bit is set.
  - Error flag sets when wlasts != (count==len) on any beat.
  - On the beat where count==len, go to W_RESP.
  - W_RESP: bvalids=1; bids=captured id; bresps=2'b10 (SLVERR) if the error flag is set, else 2'b00. Outputs hold stable until breadys, then return to W_IDLE.
  - Minimum occupancy for a 1-beat write: 3 cycles (AW, W, B).
  - W beats presented before the AW handshake are stalled (wreadys=0).
- Read FSM, states R_IDLE -> R_DATA:
  - R_IDLE: arreadys=1. On the handshake, capture id, index and len.
  - rvalids rises the cycle after the AR handshake, with rdatas registered from memory.
  - R_DATA: rvalids=1; rlasts=(count==len); rresps=2'b00.
  - On rvalids&rreadys: advance to the next beat registered the same edge, so back-to-back beats run at full rate. After the last beat, go to R_IDLE.
  - While rreadys=0, all R outputs hold stable.
- Read/write collision: write and read run concurrently. A read beat sampled in the same cycle as a write to the same word returns the old data; the write is visible one cycle later.
- awreadys/arreadys never assert while their FSM is busy, so at most one outstanding transaction per direction.

Optional Feature:
- Macro: AXI_RAM_DECERR_EN.
- When defined:
  - Any address with nonzero bits above the memory index range marks the burst out-of-range.
  - Writes are suppressed and bresps=2'b11 (DECERR).
  - Reads return rdatas=0 and rresps=2'b11 on every beat.
  - Handshake timing is unchanged.
- When undefined: those high address bits are ignored and addresses alias modulo DEPTH.

Test Plan:
- Write awaddrs=0x10, awlens=3, data 0xA0..0xA3, wlasts on beat 3 -> words 4..7 written; bvalids with bresps=00 and bids matching awids. Then read the same burst -> 0xA0..0xA3, rlasts on beat 3 only.
- Write to 0xAABBCCDD with wstrbs=4'b0101, data 0x11223344 -> readback 0xAA22CC44.
- DEPTH=256, awaddrs=0x3F8, awlens=3 -> words 254, 255, 0, 1 written; readback confirms the wrap.
- wlasts asserted on beat 1 of a 4-beat burst -> all 4 beats consumed; bresps=2'b10.
- Random rreadys/breadys backpressure with a concurrent read and write to the same word -> R/B outputs stable while stalled; the same-cycle read returns old data. Reset pulsed mid-read -> rvalids=0 immediately and arreadys=1 the first cycle after release.
